// File: rtl/step_controller.sv
// Processor step sequencer: single-step, free-run at a selectable rate, and
// automatic halt on a PC breakpoint or a halt opcode.
module step_controller #(
  parameter logic [23:0] PRESCALE = 24'd12500000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        StepPulse,
  input  logic        RunReq,
  input  logic [1:0]  RateSel,
  input  logic        BreakEn,
  input  logic [6:0]  BreakAddr,
  input  logic [6:0]  PC,
  input  logic [15:0] IR,
  output logic        StepEn,
  output logic [1:0]  State,
  output logic        Running,
  output logic        Halted,
  output logic [15:0] StepCount
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        step_nx;
  logic [23:0] prescaler;
  logic [23:0] prescaler_nx;
  logic [23:0] shifted;
  logic [23:0] reload;
  logic        stop_hit;
  logic        ir_unused;

  // The run period never drops below one clock, even when the shift empties it.
  always_comb begin
    shifted = PRESCALE >> {RateSel, 1'b0};
    if (shifted == 24'd0) begin
      reload = 24'd0;
    end else begin
      reload = shifted - 24'd1;
    end
  end

  assign stop_hit  = (BreakEn && (PC == BreakAddr)) || (IR[15:12] == HALT_OP);
  assign ir_unused = ^IR[11:0];

  always_comb begin
    state_nx     = state;
    step_nx      = 1'b0;
    prescaler_nx = prescaler;
    case (state)
      IDLE: begin
        if (StepPulse) begin
          state_nx = STEP;
          step_nx  = 1'b1;
        end else if (RunReq) begin
          state_nx     = RUN;
          prescaler_nx = reload;
        end else begin
          state_nx = IDLE;
        end
      end
      STEP: begin
        state_nx = IDLE;
      end
      RUN: begin
        // Dropping RunReq wins over a tick landing in the same cycle.
        if (!RunReq) begin
          state_nx = IDLE;
        end else if (prescaler == 24'd0) begin
          if (stop_hit) begin
            state_nx = HALT;
          end else begin
            step_nx      = 1'b1;
            prescaler_nx = reload;
          end
        end else begin
          prescaler_nx = prescaler - 24'd1;
        end
      end
      HALT: begin
        if (StepPulse) begin
          state_nx = STEP;
          step_nx  = 1'b1;
        end else if (!RunReq) begin
          state_nx = IDLE;
        end else begin
          state_nx = HALT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      prescaler <= 24'd0;
      StepEn    <= 1'b0;
      Running   <= 1'b0;
      Halted    <= 1'b0;
      StepCount <= 16'd0;
    end else begin
      state     <= state_nx;
      prescaler <= prescaler_nx;
      StepEn    <= step_nx;
      Running   <= (state_nx == RUN);
      Halted    <= (state_nx == HALT);
      if (step_nx) begin
        StepCount <= StepCount + 16'd1;
      end else begin
        StepCount <= StepCount;
      end
    end
  end

  assign State = state;

endmodule

// File: tb/tb_step_controller.sv
// Directed self-checking bench for step_controller (two instances, PRESCALE 8 and 16).
module tb_step_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        StepPulse = 1'b0;
  logic        RunReq = 1'b0;
  logic [1:0]  RateSel = 2'd0;
  logic        BreakEn = 1'b0;
  logic [6:0]  BreakAddr = 7'd0;
  logic [6:0]  PC = 7'd0;
  logic [15:0] IR = 16'd0;

  logic        a_step_en, b_step_en;
  logic [1:0]  a_state, b_state;
  logic        a_running, b_running, a_halted, b_halted;
  logic [15:0] a_count, b_count;

  int checks = 0;
  int failures = 0;
  int pulses;

  step_controller #(.PRESCALE(24'd8), .HALT_OP(4'hF)) dut8 (
    .Clock(Clock), .Reset(Reset), .StepPulse(StepPulse), .RunReq(RunReq),
    .RateSel(RateSel), .BreakEn(BreakEn), .BreakAddr(BreakAddr), .PC(PC), .IR(IR),
    .StepEn(a_step_en), .State(a_state), .Running(a_running), .Halted(a_halted),
    .StepCount(a_count)
  );

  step_controller #(.PRESCALE(24'd16), .HALT_OP(4'hF)) dut16 (
    .Clock(Clock), .Reset(Reset), .StepPulse(StepPulse), .RunReq(RunReq),
    .RateSel(RateSel), .BreakEn(BreakEn), .BreakAddr(BreakAddr), .PC(PC), .IR(IR),
    .StepEn(b_step_en), .State(b_state), .Running(b_running), .Halted(b_halted),
    .StepCount(b_count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst_state", {30'd0, b_state}, 32'd0);
    chk("rst_stepen", {31'd0, b_step_en}, 32'd0);
    chk("rst_count", {16'd0, b_count}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    // Power-up reset values before any clock edge
    #2;
    chk("init_state_a", {30'd0, a_state}, 32'd0);
    chk("init_count_a", {16'd0, a_count}, 32'd0);
    chk("init_stepen_a", {31'd0, a_step_en}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // 1: single step from IDLE
    StepPulse = 1'b1;
    tick();
    StepPulse = 1'b0;
    chk("t1_state_step", {30'd0, b_state}, 32'd1);
    chk("t1_stepen_hi", {31'd0, b_step_en}, 32'd1);
    chk("t1_count", {16'd0, b_count}, 32'd1);
    tick();
    chk("t1_state_idle", {30'd0, b_state}, 32'd0);
    chk("t1_stepen_lo", {31'd0, b_step_en}, 32'd0);
    chk("t1_count_hold", {16'd0, b_count}, 32'd1);

    // 2: free run, P=8 on the PRESCALE=8 instance
    do_reset();
    RateSel = 2'd0;
    RunReq = 1'b1;
    tick();
    chk("t2_running", {31'd0, a_running}, 32'd1);
    chk("t2_state_run", {30'd0, a_state}, 32'd2);
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (a_step_en) pulses++;
      chk($sformatf("t2_stepen_%0d", k), {31'd0, a_step_en}, (k % 8 == 0) ? 32'd1 : 32'd0);
    end
    RunReq = 1'b0;
    chk("t2_pulses", pulses, 32'd5);
    chk("t2_count", {16'd0, a_count}, 32'd5);
    tick();
    chk("t2_idle", {30'd0, a_state}, 32'd0);
    chk("t2_not_running", {31'd0, a_running}, 32'd0);

    // 3: breakpoint, P=4 on the PRESCALE=16 instance
    do_reset();
    RateSel = 2'd1;
    BreakEn = 1'b1;
    BreakAddr = 7'h05;
    PC = 7'h00;
    RunReq = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t3_stepen_%0d", k), {31'd0, b_step_en}, (k == 4 || k == 8) ? 32'd1 : 32'd0);
      if (k == 8) PC = 7'h05;
    end
    chk("t3_halt_state", {30'd0, b_state}, 32'd3);
    chk("t3_halted", {31'd0, b_halted}, 32'd1);
    chk("t3_count", {16'd0, b_count}, 32'd2);
    tick();
    chk("t3_halt_hold", {30'd0, b_state}, 32'd3);
    StepPulse = 1'b1;
    tick();
    StepPulse = 1'b0;
    chk("t3_step_over", {31'd0, b_step_en}, 32'd1);
    chk("t3_step_state", {30'd0, b_state}, 32'd1);
    chk("t3_count_step", {16'd0, b_count}, 32'd3);
    PC = 7'h00;
    tick();
    chk("t3_via_idle", {30'd0, b_state}, 32'd0);
    tick();
    chk("t3_run_resume", {30'd0, b_state}, 32'd2);

    // 4: halt opcode while running (P=4, just entered RUN)
    IR = 16'hF000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t4_no_step_%0d", k), {31'd0, b_step_en}, 32'd0);
    end
    chk("t4_halt", {30'd0, b_state}, 32'd3);
    chk("t4_halted", {31'd0, b_halted}, 32'd1);
    RunReq = 1'b0;
    IR = 16'h0000;
    tick();
    chk("t4_idle", {30'd0, b_state}, 32'd0);
    chk("t4_halted_lo", {31'd0, b_halted}, 32'd0);

    // 5: StepPulse and RunReq together, then StepPulse ignored in RUN
    do_reset();
    RateSel = 2'd1;
    BreakEn = 1'b0;
    StepPulse = 1'b1;
    RunReq = 1'b1;
    tick();
    StepPulse = 1'b0;
    chk("t5_step_first", {30'd0, b_state}, 32'd1);
    chk("t5_stepen", {31'd0, b_step_en}, 32'd1);
    tick();
    chk("t5_idle", {30'd0, b_state}, 32'd0);
    tick();
    chk("t5_run", {30'd0, b_state}, 32'd2);
    StepPulse = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t5_stepen_%0d", k), {31'd0, b_step_en}, (k == 4 || k == 8) ? 32'd1 : 32'd0);
    end
    StepPulse = 1'b0;
    chk("t5_count", {16'd0, b_count}, 32'd3);
    chk("t5_still_run", {30'd0, b_state}, 32'd2);

    // 6: wrap of StepCount using P=1 (RateSel=3 shifts PRESCALE to 0, clamped to 1)
    RunReq = 1'b0;
    do_reset();
    RateSel = 2'd3;
    RunReq = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("t6_p1_stepen_%0d", k), {31'd0, b_step_en}, 32'd1);
    end
    for (int n = 0; n < 70000 && b_count != 16'hFFFF; n++) tick();
    chk("t6_reach_ffff", {16'd0, b_count}, 32'h0000FFFF);
    RunReq = 1'b0;
    tick();
    chk("t6_idle", {30'd0, b_state}, 32'd0);
    chk("t6_hold_ffff", {16'd0, b_count}, 32'h0000FFFF);
    StepPulse = 1'b1;
    tick();
    StepPulse = 1'b0;
    chk("t6_wrap", {16'd0, b_count}, 32'd0);
    tick();

    // 6b: async reset mid-RUN drops StepEn immediately
    RunReq = 1'b1;
    tick();
    tick();
    chk("t6_pre_rst_stepen", {31'd0, b_step_en}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("t6_rst_stepen", {31'd0, b_step_en}, 32'd0);
    chk("t6_rst_state", {30'd0, b_state}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // 6c: P=1 breakpoint still evaluated every cycle
    tick();
    chk("t6_run_p1", {30'd0, b_state}, 32'd2);
    BreakEn = 1'b1;
    BreakAddr = 7'h05;
    PC = 7'h05;
    tick();
    chk("t6_p1_break_state", {30'd0, b_state}, 32'd3);
    chk("t6_p1_break_stepen", {31'd0, b_step_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Sequences the Processor's execution by generating a one-cycle step enable (StepEn) that gates the processor's advance.
- Supports three modes:
  - single-step from the debounced KEY pulse;
  - free-run at a switch-selectable rate;
  - automatic halt on a PC breakpoint or a halt opcode in IR.
- Sits between KeyFilter/switches and the Processor in ProjectB.
- Exports state and a step count for the HEX display mux.

Parameters:
- PRESCALE, 12500000, base run period in clocks (4 Hz at 50 MHz); width 24 bits.
- HALT_OP, 4'hF, IR[15:12] opcode that forces HALT while running.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Reset  in  1  asynchronous, active-low reset.
- StepPulse  in  1  one-cycle pulse from KeyFilter; request a single step.
- RunReq  in  1  level; 1 = free-run requested.
- RateSel  in  2  run period P = max(1, PRESCALE >> (2*RateSel)).
- BreakEn  in  1  enables PC breakpoint compare.
- BreakAddr  in  7  breakpoint PC value.
- PC  in  7  current processor PC.
- IR  in  16  current instruction register.
- StepEn  out  1  one-cycle processor step enable (registered).
- State  out  2  00 IDLE, 01 STEP, 10 RUN, 11 HALT.
- Running  out  1  1 when State==RUN.
- Halted  out  1  1 when State==HALT.
- StepCount  out  16  number of StepEn pulses issued, wraps.

Behaviour:
- Reset (Reset=0, async): State=IDLE, StepEn=0, StepCount=0, prescaler=0. Outputs remain in these values until the first rising Clock edge after Reset=1.
- All outputs are registered. StepEn is high for exactly one clock per step. StepCount increments in the cycle StepEn is high, and FFFF wraps to 0000.
- IDLE:
  - StepPulse=1 -> STEP. StepPulse has priority over RunReq in the same cycle.
  - Otherwise RunReq=1 -> RUN, with the prescaler loaded to P-1.
- STEP:
  - Lasts exactly one cycle with StepEn=1, then -> IDLE.
  - If RunReq is still 1, IDLE then re-enters RUN on the next edge. This is the "continue" semantic.
- RUN:
  - Prescaler decrements each clock.
  - When it reaches 0, the tick evaluates in this priority order:
    1. BreakEn=1 and PC==BreakAddr -> HALT, no StepEn.
    2. Else IR[15:12]==HALT_OP -> HALT, no StepEn.
    3. Else StepEn=1 next cycle and the prescaler reloads P-1.
  - With stable inputs, StepEn pulses are spaced exactly P clocks apart. The first pulse is P clocks after the RUN-entry edge.
  - RunReq=0 -> IDLE immediately; a pending tick is discarded.
  - StepPulse is ignored in RUN.
  - A RateSel change takes effect at the next reload.
- HALT:
  - StepEn=0.
  - StepPulse=1 -> STEP (steps over the breakpoint).
  - Else RunReq=0 -> IDLE.
  - Otherwise the block stays in HALT. A RUN re-entry with RunReq=1 requires passing through STEP.
- P=1 (e.g. PRESCALE=1): StepEn is asserted every clock in RUN. No tick is lost; break checks are still evaluated every cycle.
- Breakpoint and opcode checks use the PC/IR values present in the tick cycle.
- Reset asserted mid-RUN or mid-STEP: StepEn drops to 0 asynchronously and no partial pulse is emitted.

Test Plan:
1. Reset, then StepPulse in IDLE -> exactly one StepEn cycle. State goes 01 then 00; StepCount=1.
2. PRESCALE=8, RateSel=0, RunReq=1 for 40 clocks, PC/IR benign -> StepEn pulses at clocks 8,16,24,32,40 after RUN entry; StepCount=5.
3. PRESCALE=16, RateSel=1 (P=4), BreakEn=1, BreakAddr=7'h05, PC driven to 05 before the 3rd tick -> State=HALT, no 3rd StepEn. Then StepPulse -> one StepEn, RUN resumes.
4. RUN with IR=16'hF000 at a tick -> HALT, Halted=1. Then RunReq=0 -> IDLE.
5. Same-cycle StepPulse and RunReq rising in IDLE -> STEP first, then RUN. StepPulse pulses during RUN produce no extra StepEn.
6. Preload StepCount to FFFF via 65535 steps and step once -> 0000. Assert Reset during RUN -> StepEn=0, State=00 immediately.
